// File: rtl/ram_access_arbiter.sv
// Shares one byte-lane RAM port between instruction fetch and load/store, with alignment checks.
// Optional fetch-starvation limit enabled by defining RAM_ARB_FAIRNESS_EN.
module ram_access_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned FETCH_MAX_WAIT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [31:0]           if_rdata_o,
    output logic                  if_err_o,

    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [1:0]            d_size_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [31:0]           d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [31:0]           d_rdata_o,
    output logic                  d_err_o,

    output logic [1:0]            ram_size_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                  state_q;
    logic                    owner_fetch_q;
    logic                    busy_err_q;
    logic                    busy_load_q;
    logic                    ram_we_q;
    logic [1:0]              ram_size_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [31:0]             ram_wdata_q;
    logic                    if_rvalid_q, d_rvalid_q;
    logic                    if_err_q, d_err_q;
    logic [31:0]             if_rdata_q, d_rdata_q;

    logic                    idle;
    logic                    fetch_first;
    logic                    grant_d, grant_f;
    logic                    d_illegal, f_illegal;
    logic                    acc_err;
    logic [31:0]             resp_data;

`ifdef RAM_ARB_FAIRNESS_EN
    localparam int unsigned CntW = $clog2(FETCH_MAX_WAIT + 1) + 1;
    logic [CntW-1:0] fair_cnt_q;
`endif

    always_comb begin
        fetch_first = 1'b0;
`ifdef RAM_ARB_FAIRNESS_EN
        fetch_first = (fair_cnt_q == CntW'(FETCH_MAX_WAIT));
`endif
        // Grants are combinational but suppressed while reset is held.
        idle    = (state_q == StIdle) && rst_ni;
        grant_d = idle && d_req_i && !(fetch_first && if_req_i);
        grant_f = idle && if_req_i && !grant_d;

        unique case (d_size_i)
            2'b00:   d_illegal = 1'b0;
            2'b01:   d_illegal = d_addr_i[0];
            2'b10:   d_illegal = |d_addr_i[1:0];
            default: d_illegal = 1'b1;
        endcase
        f_illegal = |if_addr_i[1:0];
        acc_err   = grant_d ? d_illegal : f_illegal;

        resp_data = (busy_err_q || !busy_load_q) ? 32'h0 : ram_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            owner_fetch_q <= 1'b0;
            busy_err_q    <= 1'b0;
            busy_load_q   <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_size_q    <= 2'b00;
            ram_addr_q    <= '0;
            ram_wdata_q   <= 32'h0;
            if_rvalid_q   <= 1'b0;
            d_rvalid_q    <= 1'b0;
            if_err_q      <= 1'b0;
            d_err_q       <= 1'b0;
            if_rdata_q    <= 32'h0;
            d_rdata_q     <= 32'h0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_d || grant_f) begin
                        state_q       <= StBusy;
                        owner_fetch_q <= grant_f;
                        busy_err_q    <= acc_err;
                        busy_load_q   <= grant_f || !d_we_i;
                        ram_we_q      <= grant_d && d_we_i && !d_illegal;
                        ram_size_q    <= grant_d ? d_size_i : 2'b10;
                        ram_addr_q    <= grant_d ? d_addr_i : if_addr_i;
                        ram_wdata_q   <= grant_d ? d_wdata_i : 32'h0;
                    end
                end
                StBusy: begin
                    // The RAM commits/reads at this edge; the response lands in the next cycle.
                    state_q  <= StIdle;
                    ram_we_q <= 1'b0;
                    if (owner_fetch_q) begin
                        if_rvalid_q <= 1'b1;
                        if_err_q    <= busy_err_q;
                        if_rdata_q  <= resp_data;
                    end else begin
                        d_rvalid_q <= 1'b1;
                        d_err_q    <= busy_err_q;
                        d_rdata_q  <= resp_data;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef RAM_ARB_FAIRNESS_EN
    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fair_cnt_q <= '0;
        end else if (grant_d) begin
            fair_cnt_q <= if_req_i ? fair_cnt_q + CntW'(1) : '0;
        end else if (grant_f) begin
            fair_cnt_q <= '0;
        end
    end
`endif

    assign if_gnt_o    = grant_f;
    assign d_gnt_o     = grant_d;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_err_o    = if_err_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_err_o     = d_err_q;
    assign ram_size_o  = ram_size_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: vector table on both ports, contention and reset-in-BUSY sequences.
// Expected responses go into a scoreboard at grant time and are checked when rvalid pulses.
module tb_ram_access_arbiter;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          if_req, if_gnt, if_rvalid, if_err;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic [1:0]    ram_size;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = 32'h0;

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_WIDTH(AW), .FETCH_MAX_WAIT(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .if_err_o    (if_err),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_size_i    (d_size),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_gnt_o     (d_gnt),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata),
        .d_err_o     (d_err),
        .ram_size_o  (ram_size),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    // Little-endian byte RAM: writes on posedge, zero-extended read registered on negedge.
    logic [7:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata[7:0];
            if (ram_size != 2'b00) mem[(int'(ram_addr) + 1) % 1024] <= ram_wdata[15:8];
            if (ram_size == 2'b10) begin
                mem[(int'(ram_addr) + 2) % 1024] <= ram_wdata[23:16];
                mem[(int'(ram_addr) + 3) % 1024] <= ram_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        case (ram_size)
            2'b00:   ram_rdata <= {24'h0, mem[ram_addr]};
            2'b01:   ram_rdata <= {16'h0, mem[(int'(ram_addr) + 1) % 1024], mem[ram_addr]};
            default: ram_rdata <= {mem[(int'(ram_addr) + 3) % 1024], mem[(int'(ram_addr) + 2) % 1024],
                                   mem[(int'(ram_addr) + 1) % 1024], mem[ram_addr]};
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic        port;   // 1 = fetch
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;
    resp_t sb_q[$];

    task automatic sb_check(input logic port, input logic [31:0] rdata, input logic err);
        resp_t e;
        if (sb_q.size() == 0) begin
            check(port ? "unexpected_if_rvalid" : "unexpected_d_rvalid", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("resp_port", {31'h0, port}, {31'h0, e.port});
            check("resp_rdata", rdata, e.rdata);
            check("resp_err", {31'h0, err}, {31'h0, e.err});
            check("resp_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (d_rvalid && if_rvalid) check("both_rvalid", 32'd1, 32'd0);
        else if (d_rvalid) sb_check(1'b0, d_rdata, d_err);
        else if (if_rvalid) sb_check(1'b1, if_rdata, if_err);
    end

    typedef struct {
        logic          port;
        logic          we;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
    } vec_t;

    // Called at posedge+1 with the arbiter IDLE; returns at posedge+1 of the response cycle.
    task automatic do_access(input vec_t v);
        bit got = 0;
        if (v.port) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (v.port ? if_gnt : d_gnt) begin
                got = 1;
                check("other_gnt_low", {31'h0, v.port ? d_gnt : if_gnt}, 32'd0);
                sb_q.push_back('{v.port, v.exp_rdata, v.exp_err, cyc + 2});
            end
        end
        check("grant_seen", {31'h0, got}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_gnts_low", {30'h0, if_gnt, d_gnt}, 32'd0);
        check("busy_ram_we", {31'h0, ram_we}, {31'h0, !v.port && v.we && !v.exp_err});
        check("busy_ram_addr", {22'h0, ram_addr}, {22'h0, v.addr});
        @(posedge clk); #1;
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    vec_t vecs[19];
    logic exp_order[6];

    initial begin
        int ngr;
        bit got;

        vecs[0]  = '{1'b0, 1'b1, 2'b10, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b10, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 10'h013, 32'h000000A5, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 10'h012, 32'h0,        32'h0000A5AD, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'b10, 10'h011, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'b10, 10'h010, 32'h0,        32'hA5ADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b01, 10'h031, 32'h0000BEEF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 1'b0, 2'b11, 10'h030, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 10'h030, 32'h0,        32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 10'h040, 32'hFFFF1234, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 10'h040, 32'h0,        32'h00001234, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 10'h041, 32'h0,        32'h00000012, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'b11, 10'h040, 32'hCAFEF00D, 32'h0,        1'b1};
        vecs[13] = '{1'b1, 1'b0, 2'b10, 10'h040, 32'h0,        32'h00001234, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 2'b10, 10'h012, 32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b0, 1'b0, 2'b01, 10'h040, 32'h0,        32'h00001234, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 2'b10, 10'h014, 32'h11223344, 32'h0,        1'b0};
        vecs[17] = '{1'b1, 1'b0, 2'b10, 10'h014, 32'h0,        32'h11223344, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 2'b01, 10'h010, 32'h0,        32'h0000BEEF, 1'b0};

`ifdef RAM_ARB_FAIRNESS_EN
        exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // Reset with both requests active: grants must stay low.
        rst_ni = 1'b0;
        if_req = 1'b1; if_addr = 10'h004;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 10'h008; d_wdata = 32'h55AA55AA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnts", {30'h0, if_gnt, d_gnt}, 32'd0);
        check("rst_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'd0);
        check("rst_ram_we_size", {29'h0, ram_we, ram_size}, 32'd0);
        check("rst_ram_addr", {22'h0, ram_addr}, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1; if_req = 1'b0; d_req = 1'b0;

        foreach (vecs[i]) do_access(vecs[i]);

        // Contention: both requests held high, six grants observed.
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 10'h010;
        if_req = 1'b1; if_addr = 10'h040;
        ngr = 0;
        for (int k = 0; k < 40 && ngr < 6; k++) begin
            @(negedge clk);
            if (d_gnt || if_gnt) begin
                check("single_gnt", {31'h0, d_gnt && if_gnt}, 32'd0);
                check($sformatf("grant_order_%0d", ngr), {31'h0, if_gnt}, {31'h0, exp_order[ngr]});
                if (if_gnt) sb_q.push_back('{1'b1, 32'h00001234, 1'b0, cyc + 2});
                else        sb_q.push_back('{1'b0, 32'hA5ADBEEF, 1'b0, cyc + 2});
                ngr++;
            end
        end
        check("contention_grants", ngr, 6);
        @(posedge clk); #1;
        d_req = 1'b0;
        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (if_gnt) begin
                got = 1;
                sb_q.push_back('{1'b1, 32'h00001234, 1'b0, cyc + 2});
            end
        end
        check("fetch_after_d_drop", {31'h0, got}, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset lands on the edge ending a store's BUSY: store commits, response dropped.
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 10'h020; d_wdata = 32'h12345678;
        got = 0;
        for (int k = 0; k < 5 && !got; k++) begin
            @(negedge clk);
            if (d_gnt) got = 1;
        end
        check("rst_store_gnt", {31'h0, got}, 32'd1);
        @(posedge clk); #1;
        rst_ni = 1'b0; d_req = 1'b0; if_req = 1'b1; if_addr = 10'h000;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstbusy_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'd0);
        check("rstbusy_gnts", {30'h0, if_gnt, d_gnt}, 32'd0);
        check("rstbusy_ram_we_size", {29'h0, ram_we, ram_size}, 32'd0);
        check("rstbusy_ram_addr", {22'h0, ram_addr}, 32'd0);
        check("rstbusy_ram_wdata", ram_wdata, 32'd0);
        check("rstbusy_d_rdata", d_rdata, 32'd0);
        check("rstbusy_if_rdata", if_rdata, 32'd0);
        check("rstbusy_err", {30'h0, if_err, d_err}, 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1; if_req = 1'b0;
        do_access('{1'b0, 1'b0, 2'b10, 10'h020, 32'h0, 32'h12345678, 1'b0});

        repeat (4) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
